// File: rtl/alu_pipe_n.sv
// Pipelined ALU with valid/ready on both sides. Stage 0 computes and later stages are register slices.
// Define ALU_FLAGS_EN to add the {N,Z,C,V} flags port, which is carried alongside each result.
module alu_pipe_n #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ALU_FLAGS_EN
    output logic [3:0]       flags,
`endif
    output logic [WIDTH:0]   result
);

`ifdef ALU_FLAGS_EN
    localparam int PW = WIDTH + 5;
`else
    localparam int PW = WIDTH + 1;
`endif

    function automatic logic [WIDTH:0] alu_calc(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [2:0]       op);
        logic [WIDTH:0] r;
        r = '0;
        case (op)
            3'd0: r = {1'b0, x} + {1'b0, y};
            3'd1: r = {1'b0, x} - {1'b0, y};   // top bit becomes the borrow
            3'd2: r = {1'b0, x & y};
            3'd3: r = {1'b0, x | y};
            3'd4: r = {1'b0, x ^ y};
            3'd5: r = {1'b0, ~x};
            3'd6: r = {x, 1'b0};
            3'd7: r = {x[0], 1'b0, x[WIDTH-1:1]};
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef ALU_FLAGS_EN
    function automatic logic [3:0] alu_flags(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic [2:0]       op,
                                             input logic [WIDTH:0]   r);
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        logic signed [WIDTH-1:0] rs;
        logic                    v;
        xs = x;
        ys = y;
        rs = r[WIDTH-1:0];
        v  = 1'b0;
        if (op == 3'd0)
            v = ((xs < 0) == (ys < 0)) && ((rs < 0) != (xs < 0));
        else if (op == 3'd1)
            v = ((xs < 0) != (ys < 0)) && ((rs < 0) != (xs < 0));
        return {r[WIDTH-1], (r[WIDTH-1:0] == '0), r[WIDTH], v};
    endfunction
`endif

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] rdy;
    logic [PW-1:0]     pay_p [STAGES];
    logic [WIDTH:0]    res_p0;
    logic [PW-1:0]     pay_in_p0;

    // stage 0: compute
    always_comb begin
        res_p0 = alu_calc(a, b, sel);
`ifdef ALU_FLAGS_EN
        pay_in_p0 = {alu_flags(a, b, sel, res_p0), res_p0};
`else
        pay_in_p0 = res_p0;
`endif
    end

    // A stage may load if the consumer is taking the tail or any slot at or below it is empty.
    for (genvar i = 0; i < STAGES; i++) begin : g_rdy
        assign rdy[i] = out_ready || !(&vld_p[STAGES-1:i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
            for (int i = 0; i < STAGES; i++)
                pay_p[i] <= '0;
        end else begin
            if (rdy[0]) begin
                vld_p[0] <= in_valid;
                if (in_valid)
                    pay_p[0] <= pay_in_p0;
            end
            // stages 1..STAGES-1: register slices
            for (int i = 1; i < STAGES; i++) begin
                if (rdy[i]) begin
                    vld_p[i] <= vld_p[i-1];
                    pay_p[i] <= pay_p[i-1];
                end
            end
        end
    end

    assign in_ready  = !rst && rdy[0];
    assign out_valid = vld_p[STAGES-1];
    assign result    = pay_p[STAGES-1][WIDTH:0];
`ifdef ALU_FLAGS_EN
    assign flags     = pay_p[STAGES-1][WIDTH+4:WIDTH+1];
`endif

endmodule
